// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 serial receiver, 16x oversampled, feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_sink #(
    parameter int BAUD_DIV = 54,
    parameter int FIFO_AW  = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               srx_i,
    output logic [7:0]         rx_data_o,
    output logic               rx_valid_o,
    input  logic               rx_ready_i,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               frame_err_o,
    output logic               break_o,
    output logic               overrun_o,
    output logic               parity_err_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] TICK_MAX = 16'(BAUD_DIV - 1);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic s1, s2, s3, line, tick, start_edge, push, pop, full, wr, drop, drop_n;
    logic [15:0] cnt;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bitn, bitn_n;
    logic [7:0] sh, sh_n;
    logic [7:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    assign line = s2;
    assign tick = cnt == TICK_MAX;
    // s3 holds the previous synchronized sample for falling-edge detection
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= srx_i;
            s2 <= s1;
            s3 <= s2;
            cnt <= (start_edge || tick) ? '0 : cnt + 16'd1;
        end
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= WAIT_IDLE;
            scnt <= '0;
            bitn <= '0;
            sh <= '0;
            drop <= 1'b0;
        end else begin
            state <= state_n;
            scnt <= scnt_n;
            bitn <= bitn_n;
            sh <= sh_n;
            drop <= drop_n;
        end
    end
    always_comb begin
        state_n = state;
        scnt_n = (tick && state != IDLE && state != WAIT_IDLE) ? scnt + 4'd1 : scnt;
        bitn_n = bitn;
        sh_n = sh;
        drop_n = drop;
        start_edge = 1'b0;
        push = 1'b0;
        frame_err_o = 1'b0;
        break_o = 1'b0;
        parity_err_o = 1'b0;
        case (state)
            WAIT_IDLE: if (tick && line) state_n = IDLE;
            IDLE: if (s3 && !line) begin
                state_n = START;
                scnt_n = '0;
                start_edge = 1'b1;
            end
            START: if (tick && scnt == 4'd7) begin
                state_n = line ? IDLE : DATA;
                scnt_n = '0;
                bitn_n = '0;
                drop_n = 1'b0;
            end
            DATA: if (tick && scnt == 4'd15) begin
                sh_n = {line, sh[7:1]};
                bitn_n = bitn + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bitn == 3'd7) state_n = PARITY;
`else
                if (bitn == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick && scnt == 4'd15) begin
                parity_err_o = ^{sh, line};
                drop_n = ^{sh, line};
                state_n = STOP;
            end
`endif
            STOP: if (tick && scnt == 4'd15) begin
                push = line && !drop;
                frame_err_o = !line;
                break_o = !line && sh == 8'h00;
                state_n = line ? IDLE : WAIT_IDLE;
            end
            default: state_n = WAIT_IDLE;
        endcase
    end
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign pop = rx_valid_o && rx_ready_i;
    assign full = fifo_level_o == (FIFO_AW + 1)'(DEPTH);
    assign wr = push && (!full || pop);
    assign overrun_o = push && full && !pop;
    assign rx_valid_o = fifo_level_o != '0;
    assign rx_data_o = rx_valid_o ? mem[rp] : 8'h00;
    always_ff @(posedge wb_clk_i) begin
        if (wr) mem[wp] <= sh;
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wp <= '0;
            rp <= '0;
            fifo_level_o <= '0;
        end else begin
            wp <= wp + FIFO_AW'(wr);
            rp <= rp + FIFO_AW'(pop);
            fifo_level_o <= fifo_level_o + (FIFO_AW + 1)'(wr) - (FIFO_AW + 1)'(pop);
        end
    end
endmodule

// File: tb/tb_uart_rx_sink.sv
// tb_uart_rx_sink: scoreboard bench for uart_rx_sink at BAUD_DIV=4 (64 clocks per bit).
module tb_uart_rx_sink;
    localparam int BD = 4;
    localparam int BIT = 16 * BD;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    logic par_flip = 1'b0;
`else
    localparam int NBITS = 10;
`endif
    // clocks from start-bit drive to the cycle holding the stop-bit sample
    localparam int POP_AT = 2 + BD * (8 + 16 * (NBITS - 1));
    logic clk = 1'b0, rst_n = 1'b0, srx = 1'b1, ready = 1'b0;
    logic [7:0] rx_data_o;
    logic rx_valid_o, frame_err_o, break_o, overrun_o, parity_err_o;
    logic [4:0] fifo_level_o;
    int vec = 0, miss = 0;
    int fe_cnt = 0, br_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int fe0, br0, ov0, pe0;
    logic [7:0] q[$];
    uart_rx_sink #(.BAUD_DIV(BD), .FIFO_AW(4)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .srx_i(srx),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(ready),
        .fifo_level_o(fifo_level_o), .frame_err_o(frame_err_o), .break_o(break_o),
        .overrun_o(overrun_o), .parity_err_o(parity_err_o)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        fe_cnt += int'(frame_err_o);
        br_cnt += int'(break_o);
        ov_cnt += int'(overrun_o);
        pe_cnt += int'(parity_err_o);
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic snap();
        fe0 = fe_cnt; br0 = br_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {stop_b, d, 1'b0};
`endif
        for (int i = 0; i < NBITS; i++) begin
            srx = bits[i];
            repeat (BIT) @(negedge clk);
        end
        srx = 1'b1;
    endtask
    task automatic drain(input string tag);
        logic [7:0] exp;
        for (int g = 0; g < 64 && rx_valid_o; g++) begin
            vec++;
            if (q.size() == 0) begin
                miss++;
                $display("FAIL %s extra byte: got %02h want none", tag, rx_data_o);
            end else begin
                exp = q.pop_front();
                if (rx_data_o !== exp) begin
                    miss++;
                    $display("FAIL %s data: got %02h want %02h", tag, rx_data_o, exp);
                end
            end
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        vec++;
        if (q.size() != 0 || fifo_level_o !== 5'd0) begin
            miss++;
            $display("FAIL %s drain: %0d bytes missing, level %0d want 0", tag, q.size(), fifo_level_o);
        end
        q.delete();
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({rx_valid_o, rx_data_o, fifo_level_o} !== 14'd0) begin
            miss++;
            $display("FAIL reset data: got valid %b data %02h level %0d want 0", rx_valid_o, rx_data_o, fifo_level_o);
        end
        vec++;
        if ({frame_err_o, break_o, overrun_o, parity_err_o} !== 4'b0) begin
            miss++;
            $display("FAIL reset flags: got %b want 0000", {frame_err_o, break_o, overrun_o, parity_err_o});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask
    task automatic test_basic();
        snap();
        q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (8) @(negedge clk);
        vec++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== q[0] || fifo_level_o !== 5'd1) begin
            miss++;
            $display("FAIL basic head: got valid %b data %02h level %0d want 1 %02h 1", rx_valid_o, rx_data_o, fifo_level_o, q[0]);
        end
        vec++;
        if (fe_cnt - fe0 + br_cnt - br0 + ov_cnt - ov0 + pe_cnt - pe0 != 0) begin
            miss++;
            $display("FAIL basic flags: got %0d pulses want 0", fe_cnt - fe0 + br_cnt - br0 + ov_cnt - ov0 + pe_cnt - pe0);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        void'(q.pop_front());
        vec++;
        if (rx_valid_o !== 1'b0 || fifo_level_o !== 5'd0) begin
            miss++;
            $display("FAIL basic pop: got valid %b level %0d want 0 0", rx_valid_o, fifo_level_o);
        end
    endtask
    task automatic test_glitch();
        snap();
        srx = 1'b0;
        repeat (12) @(negedge clk);
        srx = 1'b1;
        repeat (100) @(negedge clk);
        vec++;
        if (fifo_level_o !== 5'd0 || fe_cnt != fe0 || br_cnt != br0) begin
            miss++;
            $display("FAIL glitch: got level %0d fe %0d brk %0d want 0 0 0", fifo_level_o, fe_cnt - fe0, br_cnt - br0);
        end
        q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        repeat (8) @(negedge clk);
        drain("glitch_next");
    endtask
    task automatic test_framing();
        snap();
        send_frame(8'hA5, 1'b0);
        repeat (20) @(negedge clk);
        vec++;
        if (fe_cnt - fe0 != 1 || br_cnt != br0 || fifo_level_o !== 5'd0) begin
            miss++;
            $display("FAIL frame_a5: got fe %0d brk %0d level %0d want 1 0 0", fe_cnt - fe0, br_cnt - br0, fifo_level_o);
        end
        snap();
        srx = 1'b0;
        repeat (2 * NBITS * BIT) @(negedge clk);
        vec++;
        if (fe_cnt - fe0 != 1 || br_cnt - br0 != 1) begin
            miss++;
            $display("FAIL break_low: got fe %0d brk %0d want 1 1", fe_cnt - fe0, br_cnt - br0);
        end
        srx = 1'b1;
        repeat (100) @(negedge clk);
        vec++;
        if (fe_cnt - fe0 != 1 || br_cnt - br0 != 1 || fifo_level_o !== 5'd0) begin
            miss++;
            $display("FAIL break_release: got fe %0d brk %0d level %0d want 1 1 0", fe_cnt - fe0, br_cnt - br0, fifo_level_o);
        end
        q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        drain("after_break");
    endtask
    task automatic test_overrun();
        snap();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            repeat (4) @(negedge clk);
        end
        vec++;
        if (fifo_level_o !== 5'd16 || ov_cnt - ov0 != 1) begin
            miss++;
            $display("FAIL overrun: got level %0d ovr %0d want 16 1", fifo_level_o, ov_cnt - ov0);
        end
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (POP_AT) @(negedge clk);
                vec++;
                if (rx_data_o !== q[0]) begin
                    miss++;
                    $display("FAIL full_pop head: got %02h want %02h", rx_data_o, q[0]);
                end
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'h11);
        repeat (8) @(negedge clk);
        vec++;
        if (fifo_level_o !== 5'd16 || ov_cnt - ov0 != 1) begin
            miss++;
            $display("FAIL full_push_pop: got level %0d ovr %0d want 16 1", fifo_level_o, ov_cnt - ov0);
        end
        drain("overrun_drain");
    endtask
    task automatic test_reset_mid();
        send_frame(8'h77, 1'b1);
        repeat (8) @(negedge clk);
        snap();
        srx = 1'b0;
        repeat (BIT * 5 + 30) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        vec++;
        if ({rx_valid_o, rx_data_o, fifo_level_o, frame_err_o, break_o, overrun_o, parity_err_o} !== 18'd0) begin
            miss++;
            $display("FAIL midreset outputs: got valid %b data %02h level %0d want all 0", rx_valid_o, rx_data_o, fifo_level_o);
        end
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        vec++;
        if (rx_valid_o !== 1'b0 || fifo_level_o !== 5'd0 || fe_cnt != fe0 || br_cnt != br0) begin
            miss++;
            $display("FAIL midreset low line: got valid %b level %0d fe %0d brk %0d want 0 0 0 0", rx_valid_o, fifo_level_o, fe_cnt - fe0, br_cnt - br0);
        end
        srx = 1'b1;
        repeat (50) @(negedge clk);
        q.delete();
        q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (8) @(negedge clk);
        drain("after_reset");
    endtask
    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        snap();
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        par_flip = 1'b0;
        repeat (8) @(negedge clk);
        vec++;
        if (pe_cnt - pe0 != 1 || fifo_level_o !== 5'd0 || fe_cnt != fe0) begin
            miss++;
            $display("FAIL parity_bad: got pe %0d level %0d fe %0d want 1 0 0", pe_cnt - pe0, fifo_level_o, fe_cnt - fe0);
        end
        q.push_back(8'h03);
        send_frame(8'h03, 1'b1);
        repeat (8) @(negedge clk);
        vec++;
        if (pe_cnt - pe0 != 1 || fe_cnt != fe0) begin
            miss++;
            $display("FAIL parity_good flags: got pe %0d fe %0d want 1 0", pe_cnt - pe0, fe_cnt - fe0);
        end
        drain("parity_good");
`else
        vec++;
        if (pe_cnt != 0) begin
            miss++;
            $display("FAIL parity_tied: got %0d pulses want 0", pe_cnt);
        end
`endif
    endtask
    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
